// File: rtl/us_ip_rx_proto_demux.sv
// -----------------------------------------------------------------------------
// us_ip_rx_proto_demux
//
// Receive-side protocol demultiplexer. Takes the IP payload stream (IP header
// already stripped) and the IP protocol field as sideband, and steers each
// packet to the ICMP output (ICMP_PROTO) or to the UDP output (UDP_PROTO).
// Packets with any other protocol are discarded. Packets longer than
// MAX_BEATS beats are cut short: the beat at position MAX_BEATS goes out with
// tlast=1 and tuser=1, and the rest of the input packet is discarded.
// Every output is registered, so an output beat appears one cycle after its
// input beat.
//
// Optional feature: define PROTO_DEMUX_STATS_EN to add saturating 32-bit
// packet counters (stat_icmp_pkts, stat_udp_pkts, stat_drop_pkts).
//
// Ports:
//   rx_axis_aclk        clock
//   rx_axis_areset      asynchronous reset, active-high
//   ip_rx_axis_*        input payload stream (no backpressure)
//   ip_rx_protocol      IP protocol field, valid on the first beat
//   icmp_rx_axis_*      ICMP payload stream out (no tready)
//   udp_rx_axis_*       UDP payload stream out (no tready)
//   drop_pulse          one-cycle pulse per discarded or truncated packet
//   stat_*_pkts         packet counters (PROTO_DEMUX_STATS_EN only)
// -----------------------------------------------------------------------------
module us_ip_rx_proto_demux #(
   parameter int         DATA_WIDTH = 64,
   parameter int         MAX_BEATS  = 188,
   parameter logic [7:0] ICMP_PROTO = 8'h01,
   parameter logic [7:0] UDP_PROTO  = 8'h11
) (
   input  logic                    rx_axis_aclk,
   input  logic                    rx_axis_areset,
   input  logic [DATA_WIDTH-1:0]   ip_rx_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] ip_rx_axis_tkeep,
   input  logic                    ip_rx_axis_tvalid,
   input  logic                    ip_rx_axis_tlast,
   input  logic                    ip_rx_axis_tuser,
   input  logic [7:0]              ip_rx_protocol,
   output logic [DATA_WIDTH-1:0]   icmp_rx_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] icmp_rx_axis_tkeep,
   output logic                    icmp_rx_axis_tvalid,
   output logic                    icmp_rx_axis_tlast,
   output logic                    icmp_rx_axis_tuser,
   output logic [DATA_WIDTH-1:0]   udp_rx_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] udp_rx_axis_tkeep,
   output logic                    udp_rx_axis_tvalid,
   output logic                    udp_rx_axis_tlast,
   output logic                    udp_rx_axis_tuser,
   output logic                    drop_pulse
`ifdef PROTO_DEMUX_STATS_EN
   ,
   output logic [31:0]             stat_icmp_pkts,
   output logic [31:0]             stat_udp_pkts,
   output logic [31:0]             stat_drop_pkts
`endif
);

   localparam int         KEEP_WIDTH = DATA_WIDTH / 8;
   localparam logic [9:0] MAX_CNT    = 10'(MAX_BEATS);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FWD_ICMP = 2'd1,
      ST_FWD_UDP  = 2'd2,
      ST_DROP     = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [9:0]              cnt_q, cnt_d;
   logic                    sticky_q, sticky_d;

   logic                    sel_icmp_s, sel_udp_s;
   logic                    out_last_s, out_user_s;
   logic                    err_s;
   logic [9:0]              beat_num_s;

   logic [DATA_WIDTH-1:0]   icmp_tdata_q, icmp_tdata_d;
   logic [KEEP_WIDTH-1:0]   icmp_tkeep_q, icmp_tkeep_d;
   logic                    icmp_tvalid_q, icmp_tvalid_d;
   logic                    icmp_tlast_q, icmp_tlast_d;
   logic                    icmp_tuser_q, icmp_tuser_d;
   logic [DATA_WIDTH-1:0]   udp_tdata_q, udp_tdata_d;
   logic [KEEP_WIDTH-1:0]   udp_tkeep_q, udp_tkeep_d;
   logic                    udp_tvalid_q, udp_tvalid_d;
   logic                    udp_tlast_q, udp_tlast_d;
   logic                    udp_tuser_q, udp_tuser_d;
   logic                    drop_q, drop_d;

   // Next-state, beat counter, sticky error and routing decision for this beat.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sticky_d   = sticky_q;
      sel_icmp_s = 1'b0;
      sel_udp_s  = 1'b0;
      out_last_s = 1'b0;
      out_user_s = 1'b0;
      drop_d     = 1'b0;
      err_s      = ip_rx_axis_tuser | sticky_q;
      beat_num_s = cnt_q + 10'd1;

      if (ip_rx_axis_tvalid) begin
         case (state_q)
            ST_IDLE: begin
               // First beat: the protocol field is only looked at here.
               if (ip_rx_protocol == ICMP_PROTO) begin
                  sel_icmp_s = 1'b1;
               end else if (ip_rx_protocol == UDP_PROTO) begin
                  sel_udp_s = 1'b1;
               end else begin
                  drop_d = 1'b1;
               end

               if (ip_rx_axis_tlast) begin
                  // Single-beat packet: never truncated since MAX_BEATS >= 2.
                  state_d    = ST_IDLE;
                  cnt_d      = 10'd0;
                  sticky_d   = 1'b0;
                  out_last_s = 1'b1;
                  out_user_s = err_s;
               end else begin
                  if (sel_icmp_s) begin
                     state_d = ST_FWD_ICMP;
                  end else if (sel_udp_s) begin
                     state_d = ST_FWD_UDP;
                  end else begin
                     state_d = ST_DROP;
                  end
                  cnt_d      = 10'd1;
                  sticky_d   = err_s;
                  out_last_s = 1'b0;
                  out_user_s = err_s;
               end
            end

            ST_FWD_ICMP, ST_FWD_UDP: begin
               sel_icmp_s = (state_q == ST_FWD_ICMP);
               sel_udp_s  = (state_q == ST_FWD_UDP);
               if (ip_rx_axis_tlast) begin
                  state_d    = ST_IDLE;
                  cnt_d      = 10'd0;
                  sticky_d   = 1'b0;
                  out_last_s = 1'b1;
                  out_user_s = err_s;
               end else if (beat_num_s == MAX_CNT) begin
                  // Over-long packet: close it here flagged as errored and
                  // swallow the remainder of the input packet.
                  state_d    = ST_DROP;
                  cnt_d      = cnt_q;
                  sticky_d   = 1'b0;
                  out_last_s = 1'b1;
                  out_user_s = 1'b1;
                  drop_d     = 1'b1;
               end else begin
                  cnt_d      = beat_num_s;
                  sticky_d   = err_s;
                  out_last_s = 1'b0;
                  out_user_s = err_s;
               end
            end

            ST_DROP: begin
               if (ip_rx_axis_tlast) begin
                  state_d  = ST_IDLE;
                  cnt_d    = 10'd0;
                  sticky_d = 1'b0;
               end else begin
                  state_d  = ST_DROP;
               end
            end

            default: begin
               state_d  = ST_IDLE;
               cnt_d    = 10'd0;
               sticky_d = 1'b0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Output beat formation: data and keep are zero unless this side is selected.
   always_comb begin
      icmp_tvalid_d = sel_icmp_s;
      icmp_tdata_d  = sel_icmp_s ? ip_rx_axis_tdata : {DATA_WIDTH{1'b0}};
      icmp_tkeep_d  = sel_icmp_s ? ip_rx_axis_tkeep : {KEEP_WIDTH{1'b0}};
      icmp_tlast_d  = sel_icmp_s & out_last_s;
      icmp_tuser_d  = sel_icmp_s & out_user_s;
      udp_tvalid_d  = sel_udp_s;
      udp_tdata_d   = sel_udp_s ? ip_rx_axis_tdata : {DATA_WIDTH{1'b0}};
      udp_tkeep_d   = sel_udp_s ? ip_rx_axis_tkeep : {KEEP_WIDTH{1'b0}};
      udp_tlast_d   = sel_udp_s & out_last_s;
      udp_tuser_d   = sel_udp_s & out_user_s;
   end

   // State, counter, sticky error and registered outputs.
   always_ff @(posedge rx_axis_aclk or posedge rx_axis_areset) begin
      if (rx_axis_areset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= 10'd0;
         sticky_q      <= 1'b0;
         icmp_tdata_q  <= {DATA_WIDTH{1'b0}};
         icmp_tkeep_q  <= {KEEP_WIDTH{1'b0}};
         icmp_tvalid_q <= 1'b0;
         icmp_tlast_q  <= 1'b0;
         icmp_tuser_q  <= 1'b0;
         udp_tdata_q   <= {DATA_WIDTH{1'b0}};
         udp_tkeep_q   <= {KEEP_WIDTH{1'b0}};
         udp_tvalid_q  <= 1'b0;
         udp_tlast_q   <= 1'b0;
         udp_tuser_q   <= 1'b0;
         drop_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         sticky_q      <= sticky_d;
         icmp_tdata_q  <= icmp_tdata_d;
         icmp_tkeep_q  <= icmp_tkeep_d;
         icmp_tvalid_q <= icmp_tvalid_d;
         icmp_tlast_q  <= icmp_tlast_d;
         icmp_tuser_q  <= icmp_tuser_d;
         udp_tdata_q   <= udp_tdata_d;
         udp_tkeep_q   <= udp_tkeep_d;
         udp_tvalid_q  <= udp_tvalid_d;
         udp_tlast_q   <= udp_tlast_d;
         udp_tuser_q   <= udp_tuser_d;
         drop_q        <= drop_d;
      end
   end

   assign icmp_rx_axis_tdata  = icmp_tdata_q;
   assign icmp_rx_axis_tkeep  = icmp_tkeep_q;
   assign icmp_rx_axis_tvalid = icmp_tvalid_q;
   assign icmp_rx_axis_tlast  = icmp_tlast_q;
   assign icmp_rx_axis_tuser  = icmp_tuser_q;
   assign udp_rx_axis_tdata   = udp_tdata_q;
   assign udp_rx_axis_tkeep   = udp_tkeep_q;
   assign udp_rx_axis_tvalid  = udp_tvalid_q;
   assign udp_rx_axis_tlast   = udp_tlast_q;
   assign udp_rx_axis_tuser   = udp_tuser_q;
   assign drop_pulse          = drop_q;

`ifdef PROTO_DEMUX_STATS_EN
   logic [31:0] stat_icmp_q, stat_icmp_d;
   logic [31:0] stat_udp_q, stat_udp_d;
   logic [31:0] stat_drop_q, stat_drop_d;

   // Saturating counters, driven from the registered output beats.
   always_comb begin
      stat_icmp_d = stat_icmp_q;
      stat_udp_d  = stat_udp_q;
      stat_drop_d = stat_drop_q;
      if (icmp_tvalid_q && icmp_tlast_q && (stat_icmp_q != 32'hFFFF_FFFF)) begin
         stat_icmp_d = stat_icmp_q + 32'd1;
      end else begin
         stat_icmp_d = stat_icmp_q;
      end
      if (udp_tvalid_q && udp_tlast_q && (stat_udp_q != 32'hFFFF_FFFF)) begin
         stat_udp_d = stat_udp_q + 32'd1;
      end else begin
         stat_udp_d = stat_udp_q;
      end
      if (drop_q && (stat_drop_q != 32'hFFFF_FFFF)) begin
         stat_drop_d = stat_drop_q + 32'd1;
      end else begin
         stat_drop_d = stat_drop_q;
      end
   end

   // Counter registers.
   always_ff @(posedge rx_axis_aclk or posedge rx_axis_areset) begin
      if (rx_axis_areset) begin
         stat_icmp_q <= 32'd0;
         stat_udp_q  <= 32'd0;
         stat_drop_q <= 32'd0;
      end else begin
         stat_icmp_q <= stat_icmp_d;
         stat_udp_q  <= stat_udp_d;
         stat_drop_q <= stat_drop_d;
      end
   end

   assign stat_icmp_pkts = stat_icmp_q;
   assign stat_udp_pkts  = stat_udp_q;
   assign stat_drop_pkts = stat_drop_q;
`endif

endmodule

// File: tb/tb_us_ip_rx_proto_demux.sv
module tb_us_ip_rx_proto_demux;

   localparam int TB_MAX = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] in_data = 64'd0;
   logic [7:0]  in_keep = 8'd0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        in_user = 1'b0;
   logic [7:0]  in_proto = 8'd0;

   logic [63:0] icmp_data, udp_data;
   logic [7:0]  icmp_keep, udp_keep;
   logic        icmp_valid, icmp_last, icmp_user;
   logic        udp_valid, udp_last, udp_user;
   logic        drop;
`ifdef PROTO_DEMUX_STATS_EN
   logic [31:0] stat_icmp, stat_udp, stat_drop;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   us_ip_rx_proto_demux #(
      .DATA_WIDTH (64),
      .MAX_BEATS  (TB_MAX),
      .ICMP_PROTO (8'h01),
      .UDP_PROTO  (8'h11)
   ) dut (
      .rx_axis_aclk        (clk),
      .rx_axis_areset      (rst),
      .ip_rx_axis_tdata    (in_data),
      .ip_rx_axis_tkeep    (in_keep),
      .ip_rx_axis_tvalid   (in_valid),
      .ip_rx_axis_tlast    (in_last),
      .ip_rx_axis_tuser    (in_user),
      .ip_rx_protocol      (in_proto),
      .icmp_rx_axis_tdata  (icmp_data),
      .icmp_rx_axis_tkeep  (icmp_keep),
      .icmp_rx_axis_tvalid (icmp_valid),
      .icmp_rx_axis_tlast  (icmp_last),
      .icmp_rx_axis_tuser  (icmp_user),
      .udp_rx_axis_tdata   (udp_data),
      .udp_rx_axis_tkeep   (udp_keep),
      .udp_rx_axis_tvalid  (udp_valid),
      .udp_rx_axis_tlast   (udp_last),
      .udp_rx_axis_tuser   (udp_user),
      .drop_pulse          (drop)
`ifdef PROTO_DEMUX_STATS_EN
      ,
      .stat_icmp_pkts      (stat_icmp),
      .stat_udp_pkts       (stat_udp),
      .stat_drop_pkts      (stat_drop)
`endif
   );

   // Observed outputs packed as {icmp beat, udp beat, drop}.
   function automatic logic [150:0] outv();
      outv = {icmp_data, icmp_keep, icmp_valid, icmp_last, icmp_user,
              udp_data, udp_keep, udp_valid, udp_last, udp_user, drop};
   endfunction

   // Expected outputs: r=1 ICMP beat, r=2 UDP beat, anything else no beat.
   function automatic logic [150:0] ex(input int r, input logic [63:0] d, input logic [7:0] k,
                                       input logic l, input logic u, input logic drp);
      logic [74:0] side;
      side = {d, k, 1'b1, l, u};
      ex = {(r == 1) ? side : 75'd0, (r == 2) ? side : 75'd0, drp};
   endfunction

   task automatic chk(input string nm, input logic [150:0] act, input logic [150:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Apply one input cycle and check the registered result right after the edge.
   task automatic step(input logic v, input logic [63:0] d, input logic [7:0] k, input logic l,
                       input logic u, input logic [7:0] p, input logic [150:0] exp, input string nm);
      @(negedge clk);
      in_valid = v; in_data = d; in_keep = k; in_last = l; in_user = u; in_proto = p;
      @(posedge clk);
      #1;
      chk(nm, outv(), exp);
   endtask

   task automatic idle(input string nm);
      step(1'b0, 64'd0, 8'd0, 1'b0, 1'b0, 8'd0, 151'd0, nm);
   endtask

   // Packet-level reference: route from the first beat's protocol, forward at
   // most TB_MAX beats with running-OR error, cut long packets, drop unknowns.
   task automatic rand_pkt(input int idx);
      int          n;
      int          route;
      logic [7:0]  proto;
      logic        err_acc;
      logic [63:0] d;
      logic [7:0]  k;
      logic        u, l, trunc;
      logic [150:0] exp;
      n = $urandom_range(1, 7);
      case ($urandom_range(0, 3))
         0: proto = 8'h01;
         1: proto = 8'h11;
         2: proto = 8'h06;
         default: proto = 8'($urandom);
      endcase
      route = (proto == 8'h01) ? 1 : (proto == 8'h11) ? 2 : 0;
      err_acc = 1'b0;
      for (int b = 0; b < n; b++) begin
         if ($urandom_range(0, 3) == 0) idle($sformatf("rnd%0d_gap", idx));
         d = {$urandom, $urandom};
         k = 8'($urandom);
         u = ($urandom_range(0, 7) == 0);
         l = (b == n - 1);
         err_acc = err_acc | u;
         if (route == 0) begin
            exp = ex(0, d, k, l, u, b == 0);
         end else if (b < TB_MAX) begin
            trunc = (b == TB_MAX - 1) && !l;
            exp = ex(route, d, k, l | trunc, err_acc | trunc, trunc);
         end else begin
            exp = 151'd0;
         end
         step(1'b1, d, k, l, u, (b == 0) ? proto : 8'($urandom), exp,
              $sformatf("rnd%0d_b%0d", idx, b));
      end
   endtask

   typedef struct {
      logic [7:0]  proto;
      logic [63:0] d;
      logic [7:0]  k;
      logic        u;
      int          route;
      logic        drp;
   } vec_t;

   vec_t tbl[6];

   initial begin
      logic [63:0] d;
      logic        u, acc;
      logic [150:0] e;

      tbl[0] = '{8'h01, 64'h1122_3344_5566_7788, 8'hff, 1'b0, 1, 1'b0};
      tbl[1] = '{8'h11, 64'hdead_beef_0bad_f00d, 8'h0f, 1'b0, 2, 1'b0};
      tbl[2] = '{8'h06, 64'h0123_4567_89ab_cdef, 8'hff, 1'b0, 0, 1'b1};
      tbl[3] = '{8'h00, 64'hffff_0000_ffff_0000, 8'h01, 1'b1, 0, 1'b1};
      tbl[4] = '{8'h11, 64'h0a0b_0c0d_0e0f_1011, 8'h03, 1'b1, 2, 1'b0};
      tbl[5] = '{8'h01, 64'h5555_aaaa_5555_aaaa, 8'h80, 1'b1, 1, 1'b0};

      // Reset state.
      @(posedge clk);
      #1;
      chk("reset_outputs", outv(), 151'd0);
      @(negedge clk);
      rst = 1'b0;

      // Single-beat packets from the table.
      for (int i = 0; i < 6; i++) begin
         step(1'b1, tbl[i].d, tbl[i].k, 1'b1, tbl[i].u, tbl[i].proto,
              ex(tbl[i].route, tbl[i].d, tbl[i].k, 1'b1, tbl[i].u, tbl[i].drp),
              $sformatf("tbl%0d", i));
      end
      idle("tbl_idle");

      // ICMP echo, 2 beats.
      step(1'b1, 64'h0001_7c4d_ed18_0008, 8'hff, 1'b0, 1'b0, 8'h01,
           ex(1, 64'h0001_7c4d_ed18_0008, 8'hff, 1'b0, 1'b0, 1'b0), "icmp_echo_b0");
      step(1'b1, 64'h6867_6665_6463_6261, 8'hff, 1'b1, 1'b0, 8'h01,
           ex(1, 64'h6867_6665_6463_6261, 8'hff, 1'b1, 1'b0, 1'b0), "icmp_echo_b1");
      idle("icmp_echo_idle");

      // UDP, 3 beats, partial last keep; protocol ignored mid-packet.
      for (int b = 0; b < 3; b++) begin
         d = 64'h1000_0000_0000_0000 + 64'(b);
         step(1'b1, d, (b == 2) ? 8'h07 : 8'hff, b == 2, 1'b0, (b == 0) ? 8'h11 : 8'h01,
              ex(2, d, (b == 2) ? 8'h07 : 8'hff, b == 2, 1'b0, 1'b0), $sformatf("udp3_b%0d", b));
      end

      // TCP 4 beats dropped, ICMP follows back-to-back.
      for (int b = 0; b < 4; b++) begin
         step(1'b1, 64'h7777 + 64'(b), 8'hff, b == 3, 1'b0, 8'h06,
              ex(0, 64'd0, 8'd0, 1'b0, 1'b0, b == 0), $sformatf("tcp_b%0d", b));
      end
      for (int b = 0; b < 2; b++) begin
         step(1'b1, 64'h4242 + 64'(b), 8'hff, b == 1, 1'b0, 8'h01,
              ex(1, 64'h4242 + 64'(b), 8'hff, b == 1, 1'b0, 1'b0), $sformatf("tcp_next_icmp_b%0d", b));
      end

      // ICMP 5 beats, error on beat 2; also over-long so beat 3 closes it.
      acc = 1'b0;
      for (int b = 0; b < 5; b++) begin
         u = (b == 2);
         acc = acc | u;
         d = 64'h5000 + 64'(b);
         if (b < 3) e = ex(1, d, 8'hff, 1'b0, acc, 1'b0);
         else if (b == 3) e = ex(1, d, 8'hff, 1'b1, 1'b1, 1'b1);
         else e = 151'd0;
         step(1'b1, d, 8'hff, b == 4, u, 8'h01, e, $sformatf("icmp_err_b%0d", b));
      end

      // UDP exactly TB_MAX beats, error on beat 1: forwarded normally.
      acc = 1'b0;
      for (int b = 0; b < TB_MAX; b++) begin
         u = (b == 1);
         acc = acc | u;
         d = 64'h6000 + 64'(b);
         step(1'b1, d, 8'hff, b == TB_MAX - 1, u, 8'h11,
              ex(2, d, 8'hff, b == TB_MAX - 1, acc, 1'b0), $sformatf("udp_max_b%0d", b));
      end
      idle("udp_max_idle");

      // ICMP 6 beats: truncated at beat 3, beats 4-5 discarded.
      for (int b = 0; b < 6; b++) begin
         d = 64'h7000 + 64'(b);
         if (b < 3) e = ex(1, d, 8'hff, 1'b0, 1'b0, 1'b0);
         else if (b == 3) e = ex(1, d, 8'hff, 1'b1, 1'b1, 1'b1);
         else e = 151'd0;
         step(1'b1, d, 8'hff, b == 5, 1'b0, 8'h01, e, $sformatf("trunc_b%0d", b));
      end
      for (int b = 0; b < 2; b++) begin
         step(1'b1, 64'h8000 + 64'(b), 8'hff, b == 1, 1'b0, 8'h11,
              ex(2, 64'h8000 + 64'(b), 8'hff, b == 1, 1'b0, 1'b0), $sformatf("after_trunc_b%0d", b));
      end

      // Randomized packets against the packet-level model.
      for (int i = 0; i < 150; i++) rand_pkt(i);
      idle("rnd_idle");

      // Reset during beat 1 of a 3-beat UDP packet.
      step(1'b1, 64'h9000, 8'hff, 1'b0, 1'b0, 8'h11,
           ex(2, 64'h9000, 8'hff, 1'b0, 1'b0, 1'b0), "rst_udp_b0");
      @(negedge clk);
      in_valid = 1'b1; in_data = 64'h9001; in_keep = 8'hff; in_last = 1'b0; in_proto = 8'h11;
      rst = 1'b1;
      #1;
      chk("rst_async_zero", outv(), 151'd0);
      @(posedge clk);
      #1;
      chk("rst_hold_zero", outv(), 151'd0);
`ifdef PROTO_DEMUX_STATS_EN
      chk("rst_stats_zero", {55'd0, stat_icmp, stat_udp, stat_drop}, 151'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      for (int b = 0; b < 2; b++) begin
         step(1'b1, 64'hA000 + 64'(b), 8'hff, b == 1, 1'b0, 8'h01,
              ex(1, 64'hA000 + 64'(b), 8'hff, b == 1, 1'b0, 1'b0), $sformatf("post_rst_icmp_b%0d", b));
      end
      idle("post_rst_idle");
`ifdef PROTO_DEMUX_STATS_EN
      chk("stats_after_icmp", {55'd0, stat_icmp, stat_udp, stat_drop}, {55'd0, 32'd1, 32'd0, 32'd0});
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
